arm_banked_regfile: RTL and testbench
=====================================

Name: arm_banked_regfile

Overview:
- ARM7-style banked general-purpose register file plus status registers, with NUM_RD registered read ports and one write port.
- Register banking follows the current CPSR mode: FIQ banks R8–R14; IRQ, SVC, ABT and UND each bank R13–R14. Each exception mode has its own SPSR.
- Atomic exception-entry sequencing is built in.
- Sits between decode (read addresses) and writeback/exception control in the core datapath.

Parameters:
- DATA_W, 32: register width.
- NUM_RD, 2: number of read ports (1–4).
- BYPASS, 1: 1 = a read of a register written in the same cycle returns the new write data.
- PC_OFFSET, 8: added to R15 on read (pipeline PC offset), modulo 2^DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rd_en  in  1  capture all read ports this cycle.
- rd_addr  in  4*NUM_RD  logical register index per port, port p at [4p+3:4p].
- rd_data  out  DATA_W*NUM_RD  registered read data, port p at [DATA_W*p +: DATA_W].
- wr_en  in  1  register write strobe.
- wr_addr  in  4  logical write index.
- wr_data  in  DATA_W  write data.
- wr_user  in  1  force user-bank mapping for this write (LDM^/STM^).
- cpsr_wr_en  in  1  CPSR write strobe.
- cpsr_wr_data  in  DATA_W  new CPSR value.
- spsr_wr_en  in  1  write SPSR of current mode.
- spsr_wr_data  in  DATA_W  new SPSR value.
- exc_en  in  1  exception entry strobe.
- exc_mode  in  5  target mode of the exception.
- exc_lr  in  DATA_W  return address to place in R14 of the target mode.
- cpsr_out  out  DATA_W  current CPSR (register output, no added latency).
- spsr_out  out  DATA_W  SPSR of current mode; 0 in USR/SYS.
- mode_err  out  1  registered; 1 when CPSR[4:0] is not a legal mode.

Behaviour:
- Mode encodings:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - SYS uses the USR bank.
  - Any other encoding is treated as USR bank, no SPSR, and sets mode_err.
- Physical storage: 31 GPRs (16 user, 7 FIQ, 2 each for IRQ/SVC/ABT/UND) and 5 SPSRs.
- Reset (asynchronous):
  - all GPRs and SPSRs = 0.
  - CPSR = 0x000000D3 (SVC, I=1, F=1).
  - rd_data = 0, mode_err = 0.
- Reads:
  - On the rising edge with rd_en=1, each port latches the mapped register for the current CPSR mode. Latency is 1 cycle.
  - With rd_en=0, rd_data holds its value.
  - R15 reads return stored R15 + PC_OFFSET.
  - With BYPASS=1, a port whose mapped physical register equals the physical register written this cycle returns the write data (plus PC_OFFSET if R15).
  - With BYPASS=0, that port returns the old value.
- Writes:
  - On the rising edge with wr_en=1, the physical register mapped by the current mode (USR mapping if wr_user=1) takes wr_data.
  - The mode is the CPSR value before this edge. A CPSR write in the same cycle affects the next cycle only.
- CPSR/SPSR:
  - cpsr_wr_en writes all DATA_W bits; a new mode takes effect on the next cycle.
  - spsr_wr_en writes the SPSR of the current mode; it is ignored in USR, SYS or an illegal mode.
- Exception entry, when exc_en=1 and exc_mode is a legal exception mode:
  - SPSR[exc_mode] = old CPSR.
  - R14[exc_mode] = exc_lr.
  - CPSR[4:0] = exc_mode and CPSR[7] (I) = 1.
  - CPSR[6] (F) = 1 only if exc_mode = FIQ.
  - CPSR[5] (T) = 0; all other bits are unchanged.
  - All of these updates happen in one edge.
  - exc_en with exc_mode = USR, SYS or illegal is ignored entirely.
- Priority in the same cycle:
  - exc_en beats cpsr_wr_en and spsr_wr_en; those are dropped.
  - exc_en beats a normal write to the same physical R14.
  - A normal write to a different register proceeds, using the old mode.
- Illegal mode: reads and writes go to the USR bank and spsr_out = 0. mode_err tracks CPSR every cycle.

Test Plan:
- Reset:
  - Assert reset mid-cycle, then deassert.
  - Required: cpsr_out = 0x000000D3, rd_data = 0, mode_err = 0. Reading R0 with rd_en returns 0 after 1 cycle.
- Banking:
  - In USR, write R13 = 0x1111.
  - Set CPSR mode to FIQ and write R13 = 0x2222, then set mode to IRQ.
  - Required: R13 reads 0 in IRQ, 0x2222 in FIQ and 0x1111 in USR. Writing R8 in FIQ does not disturb USR R8.
- Bypass / PC:
  - BYPASS=1: write R3 = 0xABCD with rd_addr0 = 3 in the same cycle; required rd_data0 = 0xABCD next cycle.
  - Write R15 = 0x100; required R15 reads 0x108. BYPASS=0 returns the old R3.
- Exception entry:
  - From CPSR = 0x00000010, pulse exc_en with exc_mode = IRQ and exc_lr = 0x44.
  - Required: CPSR = 0x00000092, SPSR_irq = 0x10, R14_irq = 0x44, USR R14 unchanged.
  - Repeat with FIQ; required CPSR[6] = 1.
- Conflicts:
  - exc_en (SVC) together with cpsr_wr_en = 0x1F and wr R14 = 0x99 in USR.
  - Required: CPSR = SVC, R14_svc = exc_lr, USR R14 = 0x99.
- Illegal mode:
  - Write CPSR[4:0] = 00101.
  - Required: mode_err = 1, spsr_out = 0, spsr_wr ignored, writes land in the USR bank.

Source files
------------

// File: rtl/arm_banked_regfile.sv
// rtl/arm_banked_regfile.sv - ARM7-style banked register file with CPSR/SPSR and exception entry
// Physical GPR map: 0-15 user, 16-22 FIQ R8-R14, 23-30 R13/R14 pairs for IRQ, SVC, ABT, UND.
module arm_banked_regfile #(
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int PC_OFFSET = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_user,
  input  logic                     cpsr_wr_en,
  input  logic [DATA_W-1:0]        cpsr_wr_data,
  input  logic                     spsr_wr_en,
  input  logic [DATA_W-1:0]        spsr_wr_data,
  input  logic                     exc_en,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_lr,
  output logic [DATA_W-1:0]        cpsr_out,
  output logic [DATA_W-1:0]        spsr_out,
  output logic                     mode_err
);
  localparam int NPHYS = 31;
  localparam int NSPSR = 5;

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  // Bank 0 = user registers and no SPSR; 1..5 = FIQ, IRQ, SVC, ABT, UND.
  function automatic logic [2:0] bank_of(input logic [4:0] m);
    case (m)
      M_FIQ:   bank_of = 3'd1;
      M_IRQ:   bank_of = 3'd2;
      M_SVC:   bank_of = 3'd3;
      M_ABT:   bank_of = 3'd4;
      M_UND:   bank_of = 3'd5;
      default: bank_of = 3'd0;
    endcase
  endfunction

  function automatic logic mode_legal(input logic [4:0] m);
    mode_legal = (m == M_USR) || (m == M_SYS) || (bank_of(m) != 3'd0);
  endfunction

  function automatic logic [4:0] phys_idx(input logic [2:0] b, input logic [3:0] a);
    phys_idx = {1'b0, a};
    if (b == 3'd1 && a >= 4'd8 && a != 4'd15)
      phys_idx = 5'd8 + {1'b0, a};
    else if (b >= 3'd2 && (a == 4'd13 || a == 4'd14))
      phys_idx = 5'd19 + {1'b0, b, 1'b0} + {4'd0, ~a[0]};
  endfunction

  logic [DATA_W-1:0]        gpr_q  [NPHYS];
  logic [DATA_W-1:0]        gpr_d  [NPHYS];
  logic [DATA_W-1:0]        spsr_q [NSPSR];
  logic [DATA_W-1:0]        spsr_d [NSPSR];
  logic [DATA_W-1:0]        cpsr_q, cpsr_d;
  logic [DATA_W*NUM_RD-1:0] rd_q, rd_d;
  logic                     mode_err_q;

  logic [2:0]        cur_bank, exc_bank;
  logic              exc_ok;
  logic [4:0]        wr_phys, exc_phys, rp;
  logic [3:0]        ra;
  logic [DATA_W-1:0] rv;

  always_comb begin
    cur_bank = bank_of(cpsr_q[4:0]);
    exc_bank = bank_of(exc_mode);
    exc_ok   = exc_en && (exc_bank != 3'd0);
    wr_phys  = phys_idx(wr_user ? 3'd0 : cur_bank, wr_addr);
    exc_phys = phys_idx(exc_bank, 4'd14);

    // Exception LR write is applied last so it wins over a normal write to the same R14.
    gpr_d = gpr_q;
    if (wr_en)  gpr_d[wr_phys]  = wr_data;
    if (exc_ok) gpr_d[exc_phys] = exc_lr;

    spsr_d = spsr_q;
    cpsr_d = cpsr_q;
    if (exc_ok) begin
      spsr_d[exc_bank - 3'd1] = cpsr_q;
      cpsr_d[7]   = 1'b1;
      if (exc_bank == 3'd1) cpsr_d[6] = 1'b1;
      cpsr_d[5]   = 1'b0;
      cpsr_d[4:0] = exc_mode;
    end else begin
      if (spsr_wr_en && cur_bank != 3'd0) spsr_d[cur_bank - 3'd1] = spsr_wr_data;
      if (cpsr_wr_en) cpsr_d = cpsr_wr_data;
    end

    rd_d = rd_q;
    ra   = '0;
    rp   = '0;
    rv   = '0;
    if (rd_en) begin
      for (int p = 0; p < NUM_RD; p++) begin
        ra = rd_addr[4*p +: 4];
        rp = phys_idx(cur_bank, ra);
        rv = (BYPASS != 0) ? gpr_d[rp] : gpr_q[rp];
        if (ra == 4'd15) rv = rv + DATA_W'(PC_OFFSET);
        rd_d[DATA_W*p +: DATA_W] = rv;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) gpr_q[i] <= '0;
      for (int i = 0; i < NSPSR; i++) spsr_q[i] <= '0;
      cpsr_q     <= DATA_W'(32'h0000_00D3);
      rd_q       <= '0;
      mode_err_q <= 1'b0;
    end else begin
      gpr_q      <= gpr_d;
      spsr_q     <= spsr_d;
      cpsr_q     <= cpsr_d;
      rd_q       <= rd_d;
      mode_err_q <= ~mode_legal(cpsr_d[4:0]);
    end
  end

  assign rd_data  = rd_q;
  assign cpsr_out = cpsr_q;
  assign spsr_out = (cur_bank != 3'd0) ? spsr_q[cur_bank - 3'd1] : '0;
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_arm_banked_regfile.sv
// tb/tb_arm_banked_regfile.sv - directed and random checks of arm_banked_regfile against a mode-view model
module tb_arm_banked_regfile;
  localparam int W  = 32;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, rd_en, wr_en, wr_user, cpsr_wr_en, spsr_wr_en, exc_en;
  logic [4*NR-1:0] rd_addr;
  logic [3:0]      wr_addr;
  logic [W-1:0]    wr_data, cpsr_wr_data, spsr_wr_data, exc_lr;
  logic [4:0]      exc_mode;
  logic [W*NR-1:0] rd_a, rd_b;
  logic [W-1:0]    cpsr_a, cpsr_b, spsr_a, spsr_b;
  logic            err_a, err_b;

  arm_banked_regfile #(.DATA_W(W), .NUM_RD(NR), .BYPASS(1), .PC_OFFSET(8)) dut_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_user(wr_user),
    .cpsr_wr_en(cpsr_wr_en), .cpsr_wr_data(cpsr_wr_data),
    .spsr_wr_en(spsr_wr_en), .spsr_wr_data(spsr_wr_data),
    .exc_en(exc_en), .exc_mode(exc_mode), .exc_lr(exc_lr),
    .cpsr_out(cpsr_a), .spsr_out(spsr_a), .mode_err(err_a));

  arm_banked_regfile #(.DATA_W(W), .NUM_RD(NR), .BYPASS(0), .PC_OFFSET(8)) dut_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_user(wr_user),
    .cpsr_wr_en(cpsr_wr_en), .cpsr_wr_data(cpsr_wr_data),
    .spsr_wr_en(spsr_wr_en), .spsr_wr_data(spsr_wr_data),
    .exc_en(exc_en), .exc_mode(exc_mode), .exc_lr(exc_lr),
    .cpsr_out(cpsr_b), .spsr_out(spsr_b), .mode_err(err_b));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: each bank holds a full 16-entry view; owner() says which bank really stores a register.
  logic [W-1:0] m_reg [0:5][0:15];
  logic [W-1:0] m_spsr [1:5];
  logic [W-1:0] m_cpsr;
  logic [W-1:0] m_rda [NR];
  logic [W-1:0] m_rdb [NR];

  function automatic int bank_of(logic [4:0] m);
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic bit legal(logic [4:0] m);
    return (m == 5'b10000) || (m == 5'b11111) || (bank_of(m) != 0);
  endfunction

  function automatic int owner(int b, int r);
    if (b == 1 && r >= 8 && r <= 14) return 1;
    if (b >= 2 && (r == 13 || r == 14)) return b;
    return 0;
  endfunction

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 6; b++)
      for (int r = 0; r < 16; r++) m_reg[b][r] = '0;
    for (int b = 1; b <= 5; b++) m_spsr[b] = '0;
    m_cpsr = 32'hD3;
    for (int p = 0; p < NR; p++) begin m_rda[p] = '0; m_rdb[p] = '0; end
  endtask

  task automatic check_all();
    int cb;
    cb = bank_of(m_cpsr[4:0]);
    chk("cpsr", cpsr_a, m_cpsr);
    chk("spsr", spsr_a, (cb != 0) ? m_spsr[cb] : '0);
    chk("mode_err", {31'd0, err_a}, {31'd0, !legal(m_cpsr[4:0])});
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rd_byp%0d", p), rd_a[W*p +: W], m_rda[p]);
      chk($sformatf("rd_nobyp%0d", p), rd_b[W*p +: W], m_rdb[p]);
    end
  endtask

  task automatic cycle();
    logic [W-1:0] nreg [0:5][0:15];
    int cb, eb;
    bit exc_ok;
    nreg   = m_reg;
    cb     = bank_of(m_cpsr[4:0]);
    eb     = bank_of(exc_mode);
    exc_ok = exc_en && eb != 0;
    if (wr_en) nreg[owner(wr_user ? 0 : cb, int'(wr_addr))][wr_addr] = wr_data;
    if (exc_ok) nreg[eb][14] = exc_lr;
    if (rd_en) begin
      for (int p = 0; p < NR; p++) begin
        int a, o;
        a = int'(rd_addr[4*p +: 4]);
        o = owner(cb, a);
        m_rda[p] = nreg[o][a] + ((a == 15) ? 32'd8 : 32'd0);
        m_rdb[p] = m_reg[o][a] + ((a == 15) ? 32'd8 : 32'd0);
      end
    end
    if (exc_ok) begin
      m_spsr[eb] = m_cpsr;
      m_cpsr = {m_cpsr[W-1:8], 1'b1, (eb == 1) ? 1'b1 : m_cpsr[6], 1'b0, exc_mode};
    end else begin
      if (spsr_wr_en && cb != 0) m_spsr[cb] = spsr_wr_data;
      if (cpsr_wr_en) m_cpsr = cpsr_wr_data;
    end
    m_reg = nreg;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_user = 0;
    cpsr_wr_en = 0; cpsr_wr_data = '0; spsr_wr_en = 0; spsr_wr_data = '0;
    exc_en = 0; exc_mode = '0; exc_lr = '0;
  endtask

  task automatic set_cpsr(logic [W-1:0] v);
    idle(); cpsr_wr_en = 1; cpsr_wr_data = v; cycle();
  endtask

  task automatic wr(logic [3:0] a, logic [W-1:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d; cycle();
  endtask

  task automatic rd2(logic [3:0] a0, logic [3:0] a1);
    idle(); rd_en = 1; rd_addr = {a1, a0}; cycle();
  endtask

  task automatic exc(logic [4:0] m, logic [W-1:0] lr);
    idle(); exc_en = 1; exc_mode = m; exc_lr = lr; cycle();
  endtask

  logic [4:0]   modes [9] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111,
                              5'b11011, 5'b11111, 5'b00101, 5'b01010};
  logic [W-1:0] tmp;

  initial begin
    reset = 0;
    idle();
    @(posedge clk);
    #3 reset = 1;
    #1;
    model_reset();
    check_all();
    chk("reset_cpsr", cpsr_a, 32'hD3);
    @(posedge clk);
    #1 reset = 0;
    check_all();

    rd2(0, 0);
    chk("r0_after_reset", rd_a[31:0], 32'h0);

    set_cpsr(32'h10);
    wr(13, 32'h1111);
    set_cpsr(32'h11);
    wr(13, 32'h2222);
    wr(8, 32'h8888);
    set_cpsr(32'h12);
    rd2(13, 8);
    chk("r13_irq", rd_a[31:0], 32'h0);
    set_cpsr(32'h11);
    rd2(13, 8);
    chk("r13_fiq", rd_a[31:0], 32'h2222);
    chk("r8_fiq", rd_a[63:32], 32'h8888);
    set_cpsr(32'h10);
    rd2(13, 8);
    chk("r13_usr", rd_a[31:0], 32'h1111);
    chk("r8_usr", rd_a[63:32], 32'h0);

    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hABCD; rd_en = 1; rd_addr = {4'd15, 4'd3}; cycle();
    chk("bypass_r3", rd_a[31:0], 32'hABCD);
    chk("nobypass_r3", rd_b[31:0], 32'h0);
    idle(); wr_en = 1; wr_addr = 15; wr_data = 32'h100; rd_en = 1; rd_addr = {4'd3, 4'd15}; cycle();
    chk("bypass_pc", rd_a[31:0], 32'h108);
    chk("nobypass_pc", rd_b[31:0], 32'h8);
    rd2(15, 3);
    chk("pc_read", rd_b[31:0], 32'h108);

    exc(5'b10010, 32'h44);
    chk("irq_cpsr", cpsr_a, 32'h92);
    chk("irq_spsr", spsr_a, 32'h10);
    rd2(14, 13);
    chk("r14_irq", rd_a[31:0], 32'h44);
    set_cpsr(32'h10);
    rd2(14, 0);
    chk("r14_usr_kept", rd_a[31:0], 32'h0);
    exc(5'b10001, 32'h55);
    chk("fiq_cpsr", cpsr_a, 32'hD1);
    chk("fiq_fbit", {31'd0, cpsr_a[6]}, 32'h1);

    set_cpsr(32'h10);
    idle();
    exc_en = 1; exc_mode = 5'b10011; exc_lr = 32'h66;
    cpsr_wr_en = 1; cpsr_wr_data = 32'h1F;
    wr_en = 1; wr_addr = 14; wr_data = 32'h99;
    spsr_wr_en = 1; spsr_wr_data = 32'h1234;
    cycle();
    chk("conf_cpsr", cpsr_a, 32'h93);
    chk("conf_spsr", spsr_a, 32'h10);
    rd2(14, 0);
    chk("conf_r14_svc", rd_a[31:0], 32'h66);
    idle(); exc_en = 1; exc_mode = 5'b10011; exc_lr = 32'h77; wr_en = 1; wr_addr = 14; wr_data = 32'h88; cycle();
    rd2(14, 0);
    chk("same_r14_exc_wins", rd_a[31:0], 32'h77);
    set_cpsr(32'h10);
    rd2(14, 0);
    chk("conf_r14_usr", rd_a[31:0], 32'h99);

    exc(5'b10000, 32'hBAD);
    exc(5'b00101, 32'hBAD);
    chk("exc_ignored", cpsr_a, 32'h10);

    set_cpsr(32'h05);
    chk("illegal_err", {31'd0, err_a}, 32'h1);
    idle(); spsr_wr_en = 1; spsr_wr_data = 32'hDEAD; wr_en = 1; wr_addr = 13; wr_data = 32'h7777; cycle();
    chk("illegal_spsr", spsr_a, 32'h0);
    set_cpsr(32'h10);
    rd2(13, 0);
    chk("illegal_wr_usr", rd_a[31:0], 32'h7777);

    for (int i = 0; i < 400; i++) begin
      idle();
      rd_en = ($urandom_range(0, 3) != 0);
      rd_addr = 8'($urandom);
      wr_en = $urandom_range(0, 1);
      wr_addr = 4'($urandom);
      wr_data = $urandom;
      wr_user = ($urandom_range(0, 7) == 0);
      cpsr_wr_en = ($urandom_range(0, 5) == 0);
      tmp = $urandom;
      tmp[4:0] = modes[$urandom_range(0, 8)];
      cpsr_wr_data = tmp;
      spsr_wr_en = ($urandom_range(0, 5) == 0);
      spsr_wr_data = $urandom;
      exc_en = ($urandom_range(0, 9) == 0);
      exc_mode = modes[$urandom_range(0, 8)];
      exc_lr = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
